// File: rtl/conv_mem_responder.sv
// Memory-side responder for the CONV engine: image ROM loaded by the host,
// five CONV layer banks, start/completion handshake and a host bank dump port.
module conv_mem_responder #(
    parameter int DW    = 20,
    parameter int AW    = 12,
    parameter int L1_AW = 10,
    parameter int L2_AW = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_full,
    output logic          ready,
    input  logic          busy,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] idata,
    input  logic          cwr,
    input  logic [AW-1:0] caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    input  logic          crd,
    input  logic [AW-1:0] caddr_rd,
    output logic [DW-1:0] cdata_rd,
    input  logic [2:0]    csel,
    output logic          done,
    output logic          sel_err,
    input  logic          dump_start,
    input  logic [2:0]    dump_sel,
    output logic          dump_valid,
    input  logic          dump_ready,
    output logic [AW-1:0] dump_addr,
    output logic [DW-1:0] dump_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_KICK, S_RUN, S_RUNB, S_DONE, S_DUMP
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          ld_full_q, ld_full_d;
    logic          done_q, done_d;
    logic          sel_err_q, sel_err_d;
    logic [2:0]    dsel_q, dsel_d;
    logic [AW-1:0] daddr_q, daddr_d;

    logic [DW-1:0] img  [2**AW];
    logic [DW-1:0] l0k0 [2**AW];
    logic [DW-1:0] l0k1 [2**AW];
    logic [DW-1:0] l1k0 [2**L1_AW];
    logic [DW-1:0] l1k1 [2**L1_AW];
    logic [DW-1:0] l2   [2**L2_AW];

    logic          img_we;
    logic          csel_ok;
    logic          dsel_ok;
    logic [AW-1:0] dump_last;

    assign csel_ok = (csel != 3'd0) && (csel <= 3'd5);
    assign dsel_ok = (dump_sel != 3'd0) && (dump_sel <= 3'd5);
    assign img_we  = ld_valid && !ld_full_q && (state_q == S_IDLE || state_q == S_LOAD);

    always_comb begin
        case (dsel_q)
            3'd1, 3'd2: dump_last = AW'(2**AW - 1);
            3'd3, 3'd4: dump_last = AW'(2**L1_AW - 1);
            default:    dump_last = AW'(2**L2_AW - 1);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        ld_full_d = ld_full_q;
        done_d    = done_q;
        dsel_d    = dsel_q;
        daddr_d   = daddr_q;
        sel_err_d = sel_err_q | ((cwr | crd) & ~csel_ok);

        case (state_q)
            S_IDLE, S_LOAD: begin
                if (img_we) begin
                    state_d = S_LOAD;
                    if (ptr_q == AW'(2**AW - 1)) begin
                        ld_full_d = 1'b1;
                        state_d   = S_KICK;
                    end else begin
                        ptr_d = ptr_q + AW'(1);
                    end
                end
            end
            S_KICK: state_d = S_RUN;
            S_RUN:  if (busy) state_d = S_RUNB;
            S_RUNB: begin
                if (!busy) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (dump_start && dsel_ok) begin
                    dsel_d  = dump_sel;
                    daddr_d = '0;
                    state_d = S_DUMP;
                end
            end
            S_DUMP: begin
                if (dump_ready) begin
                    if (daddr_q == dump_last) begin
                        daddr_d = '0;
                        state_d = S_DONE;
                    end else begin
                        daddr_d = daddr_q + AW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            ld_full_q <= 1'b0;
            done_q    <= 1'b0;
            sel_err_q <= 1'b0;
            dsel_q    <= '0;
            daddr_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            ld_full_q <= ld_full_d;
            done_q    <= done_d;
            sel_err_q <= sel_err_d;
            dsel_q    <= dsel_d;
            daddr_q   <= daddr_d;
        end
    end

    // Storage is deliberately outside the reset domain: contents survive reset.
    always_ff @(posedge clk) begin
        if (img_we) img[ptr_q] <= ld_data;
        if (cwr) begin
            case (csel)
                3'd1:    l0k0[caddr_wr] <= cdata_wr;
                3'd2:    l0k1[caddr_wr] <= cdata_wr;
                3'd3:    l1k0[caddr_wr[L1_AW-1:0]] <= cdata_wr;
                3'd4:    l1k1[caddr_wr[L1_AW-1:0]] <= cdata_wr;
                3'd5:    l2[caddr_wr[L2_AW-1:0]] <= cdata_wr;
                default: ;
            endcase
        end
    end

    always_comb begin
        cdata_rd = '0;
        if (crd) begin
            case (csel)
                3'd1:    cdata_rd = l0k0[caddr_rd];
                3'd2:    cdata_rd = l0k1[caddr_rd];
                3'd3:    cdata_rd = l1k0[caddr_rd[L1_AW-1:0]];
                3'd4:    cdata_rd = l1k1[caddr_rd[L1_AW-1:0]];
                3'd5:    cdata_rd = l2[caddr_rd[L2_AW-1:0]];
                default: cdata_rd = '0;
            endcase
        end
    end

    always_comb begin
        dump_data = '0;
        if (state_q == S_DUMP) begin
            case (dsel_q)
                3'd1:    dump_data = l0k0[daddr_q];
                3'd2:    dump_data = l0k1[daddr_q];
                3'd3:    dump_data = l1k0[daddr_q[L1_AW-1:0]];
                3'd4:    dump_data = l1k1[daddr_q[L1_AW-1:0]];
                default: dump_data = l2[daddr_q[L2_AW-1:0]];
            endcase
        end
    end

    assign idata      = img[iaddr];
    assign ld_full    = ld_full_q;
    assign ready      = (state_q == S_KICK);
    assign done       = done_q;
    assign sel_err    = sel_err_q;
    assign dump_valid = (state_q == S_DUMP);
    assign dump_addr  = daddr_q;

endmodule

// File: tb/tb_conv_mem_responder.sv
// Directed bench for conv_mem_responder: image load, kick, layer banks,
// done handshake, bank dump and reset abort.
module tb_conv_mem_responder;

    localparam int DW = 20;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_full;
    logic          ready;
    logic          busy;
    logic [AW-1:0] iaddr;
    logic [DW-1:0] idata;
    logic          cwr;
    logic [AW-1:0] caddr_wr;
    logic [DW-1:0] cdata_wr;
    logic          crd;
    logic [AW-1:0] caddr_rd;
    logic [DW-1:0] cdata_rd;
    logic [2:0]    csel;
    logic          done;
    logic          sel_err;
    logic          dump_start;
    logic [2:0]    dump_sel;
    logic          dump_valid;
    logic          dump_ready;
    logic [AW-1:0] dump_addr;
    logic [DW-1:0] dump_data;

    int vecs = 0;
    int errs = 0;
    int ready_cnt = 0;

    conv_mem_responder #(.DW(DW), .AW(AW), .L1_AW(10), .L2_AW(11)) dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_full(ld_full),
        .ready(ready), .busy(busy),
        .iaddr(iaddr), .idata(idata),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
        .csel(csel), .done(done), .sel_err(sel_err),
        .dump_start(dump_start), .dump_sel(dump_sel),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_addr(dump_addr), .dump_data(dump_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ready === 1'b1) ready_cnt <= ready_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, observed running, expected finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_image(input logic [DW-1:0] mask);
        for (int i = 0; i < 4096; i++) begin
            ld_valid = 1'b1;
            ld_data  = DW'(i) ^ mask;
            tick();
            if (i == 4094) begin
                chk("ld_full_before_last", 32'(ld_full), 32'd0);
                chk("ready_before_last", 32'(ready), 32'd0);
            end
        end
        ld_valid = 1'b0;
        chk("ld_full_after_last", 32'(ld_full), 32'd1);
        chk("ready_kick", 32'(ready), 32'd1);
    endtask

    initial begin
        int hs;
        int cyc;
        logic [DW-1:0] exp_d;

        reset = 1'b0; ld_valid = 1'b0; ld_data = '0; busy = 1'b0; iaddr = '0;
        cwr = 1'b0; caddr_wr = '0; cdata_wr = '0; crd = 1'b0; caddr_rd = '0;
        csel = '0; dump_start = 1'b0; dump_sel = '0; dump_ready = 1'b0;
        tick(); tick();
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_ld_full", 32'(ld_full), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sel_err", 32'(sel_err), 32'd0);
        chk("rst_dump_valid", 32'(dump_valid), 32'd0);
        chk("rst_dump_addr", 32'(dump_addr), 32'd0);
        chk("rst_dump_data", 32'(dump_data), 32'd0);
        reset = 1'b1;
        tick();

        load_image('0);
        // Extra word during KICK and RUN must be ignored.
        ld_valid = 1'b1; ld_data = 20'hFFFFF;
        tick();
        chk("ready_one_pulse", 32'(ready), 32'd0);
        tick();
        ld_valid = 1'b0;
        chk("ready_still_low", 32'(ready), 32'd0);
        chk("ready_count", 32'(ready_cnt), 32'd1);
        iaddr = 12'h000; #1;
        chk("image0_kept", 32'(idata), 32'h0);
        iaddr = 12'hABC; #1;
        chk("idata_abc", 32'(idata), 32'h00ABC);
        iaddr = 12'hFFF; #1;
        chk("idata_fff", 32'(idata), 32'h00FFF);

        cwr = 1'b1; csel = 3'd3; caddr_wr = 12'hC05; cdata_wr = 20'h12345;
        tick();
        cwr = 1'b0; crd = 1'b1; caddr_rd = 12'h005; #1;
        chk("l1k0_trunc", 32'(cdata_rd), 32'h12345);
        crd = 1'b0; #1;
        chk("crd_low_zero", 32'(cdata_rd), 32'h0);

        cwr = 1'b1; csel = 3'd5; caddr_wr = 12'h010; cdata_wr = 20'h00001;
        tick();
        crd = 1'b1; caddr_rd = 12'h010; cdata_wr = 20'h00002; #1;
        chk("l2_rw_old", 32'(cdata_rd), 32'h00001);
        tick();
        cwr = 1'b0; #1;
        chk("l2_rw_new", 32'(cdata_rd), 32'h00002);
        crd = 1'b0;
        chk("sel_err_clear", 32'(sel_err), 32'd0);

        cwr = 1'b1; csel = 3'd7; caddr_wr = 12'h010; cdata_wr = 20'h00003;
        tick();
        cwr = 1'b0;
        chk("sel_err_set", 32'(sel_err), 32'd1);
        crd = 1'b1; #1;
        chk("bad_csel_rd_zero", 32'(cdata_rd), 32'h0);
        csel = 3'd5; #1;
        chk("l2_untouched", 32'(cdata_rd), 32'h00002);
        crd = 1'b0;
        tick();
        chk("sel_err_sticky", 32'(sel_err), 32'd1);

        tick(); tick();
        chk("done_wait_rise", 32'(done), 32'd0);
        busy = 1'b1;
        tick(); tick(); tick();
        chk("done_while_busy", 32'(done), 32'd0);
        busy = 1'b0;
        tick();
        chk("done_after_fall", 32'(done), 32'd1);

        for (int a = 0; a < 1024; a++) begin
            cwr = 1'b1; csel = 3'd4; caddr_wr = AW'(a) | 12'hC00;
            cdata_wr = DW'(a) ^ 20'hA5A00;
            tick();
        end
        cwr = 1'b0; csel = 3'd0;

        dump_start = 1'b1; dump_sel = 3'd0;
        tick();
        chk("dump_bad_sel_ignored", 32'(dump_valid), 32'd0);
        dump_sel = 3'd4;
        tick();
        dump_start = 1'b0;
        chk("dump_first_data", 32'(dump_data), 32'hA5A00);
        hs = 0; cyc = 0;
        while (hs < 1024 && cyc < 4000) begin
            dump_ready = cyc[0];
            exp_d = DW'(hs) ^ 20'hA5A00;
            #1;
            chk("dump_valid", 32'(dump_valid), 32'd1);
            chk("dump_addr", 32'(dump_addr), 32'(hs));
            chk("dump_data", 32'(dump_data), 32'(exp_d));
            if (dump_ready) hs++;
            tick();
            cyc++;
        end
        dump_ready = 1'b0;
        chk("dump_handshakes", 32'(hs), 32'd1024);
        chk("dump_valid_drop", 32'(dump_valid), 32'd0);
        chk("done_still_set", 32'(done), 32'd1);

        dump_start = 1'b1; dump_sel = 3'd4;
        tick();
        dump_start = 1'b0;
        chk("redump_valid", 32'(dump_valid), 32'd1);
        chk("redump_addr", 32'(dump_addr), 32'd0);
        #2 reset = 1'b0; #1;
        chk("abort_dump_valid", 32'(dump_valid), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sel_err", 32'(sel_err), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        load_image(20'h30000);
        tick();
        busy = 1'b1;
        tick();
        chk("ready_count2", 32'(ready_cnt), 32'd2);
        #2 reset = 1'b0; #1;
        chk("run_rst_done", 32'(done), 32'd0);
        chk("run_rst_ready", 32'(ready), 32'd0);
        chk("run_rst_ld_full", 32'(ld_full), 32'd0);
        busy = 1'b0;
        iaddr = 12'hABC; #1;
        chk("image_not_cleared", 32'(idata), 32'h30ABC);
        tick();
        reset = 1'b1;
        tick();
        ld_valid = 1'b1; ld_data = 20'h0BEEF;
        tick();
        ld_valid = 1'b0;
        iaddr = 12'h000; #1;
        chk("idle_accepts_word0", 32'(idata), 32'h0BEEF);
        chk("reload_not_full", 32'(ld_full), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
